// File: rtl/stack8_ctrl_if.sv
// Command/response handshake bundle for the 8-deep stack controller.
// The master issues push/pop commands and consumes pop responses.
interface stack8_ctrl_if;
  logic        cmd_valid;
  logic        cmd_op;     // 0 = push, 1 = pop
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack8_ctrl.sv
// LIFO controller over an external 8-word register memory (combinational read).
// Pushes write in the accept cycle; pops read one cycle later from the decremented index.
module stack8_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  stack8_ctrl_if.slave     bus,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic [2:0]       mem_address,
  output logic             mem_load,
  output logic [15:0]      mem_in,
  input  logic [15:0]      mem_out
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t      state;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;
  logic        push_acc;
  logic        pop_acc;

  assign full  = (count == 4'd8);
  assign empty = (count == 4'd0);

  // Commands are blocked while held in reset or flushing.
  assign bus.cmd_ready = rst_n && !clr && (state == IDLE);
  assign push_acc      = bus.cmd_valid && bus.cmd_ready && !bus.cmd_op;
  assign pop_acc       = bus.cmd_valid && bus.cmd_ready &&  bus.cmd_op;

  // count is the write slot when idle and the top index once a pop has decremented it.
  assign mem_address = count[2:0];
  assign mem_in      = bus.cmd_data;
  assign mem_load    = push_acc && !full;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= 4'd0;
      rsp_data_q    <= 16'h0000;
      rsp_err_q     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clr) begin
      state         <= IDLE;
      count         <= 4'd0;
      rsp_err_q     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push_acc) begin
            if (!full) count        <= count + 4'd1;
            else       overflow_err <= 1'b1;
          end else if (pop_acc) begin
            if (!empty) begin
              count <= count - 4'd1;
              state <= READ;
            end else begin
              rsp_data_q    <= 16'h0000;
              rsp_err_q     <= 1'b1;
              underflow_err <= 1'b1;
              state         <= RESP;
            end
          end
        end
        READ: begin
          rsp_data_q <= mem_out;
          rsp_err_q  <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_err_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack8_ctrl.sv
// Self-checking bench for stack8_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based LIFO reference model.
module tb_stack8_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  count;
  logic        full, empty, overflow_err, underflow_err;
  logic [2:0]  mem_address;
  logic        mem_load;
  logic [15:0] mem_in, mem_out;
  logic [15:0] mem [8];

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [15:0] stk[$];
  bit          m_ovf, m_unf;

  stack8_ctrl_if bus();

  stack8_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus.slave),
    .count(count), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .mem_address(mem_address), .mem_load(mem_load), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_load) mem[mem_address] <= mem_in;
  assign mem_out = mem[mem_address];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic quiet;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_data = 16'h0; bus.rsp_ready = 1'b0; clr = 1'b0;
  endtask

  task automatic flush;
    clr = 1'b1; tick; clr = 1'b0;
    stk.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic push_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_data = base + 16'(i);
      tick;
      stk.push_back(base + 16'(i));
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    quiet; rst_n = 1'b0; clr = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_data = 16'h1234; #1;
    n_chk++; if (mem_load !== 1'b0) begin n_fail++; $display("FAIL reset_mem_load got %b want 0", mem_load); end
    n_chk++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 0", bus.cmd_ready); end
    tick; tick;
    n_chk++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_count got %0d e=%b f=%b want 0 1 0", count, empty, full); end
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got v=%b d=%h e=%b want 0 0000 0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
    n_chk++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_errs got %b%b want 00", overflow_err, underflow_err); end
    quiet; rst_n = 1'b1; #1;
    n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", bus.cmd_ready); end
    stk.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_push_pop;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h3333; exp_d[1] = 16'h2222; exp_d[2] = 16'h1111;
    quiet; flush;
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_data = 16'h1111 * 16'(i + 1); #1;
      n_chk++; if (bus.cmd_ready !== 1'b1 || mem_load !== 1'b1) begin n_fail++; $display("FAIL b2b_push%0d got rdy=%b load=%b want 1 1", i, bus.cmd_ready, mem_load); end
      tick;
    end
    bus.cmd_valid = 1'b0;
    n_chk++; if (count !== 4'd3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.rsp_ready = 1'b1;
      tick; bus.cmd_valid = 1'b0;
      n_chk++; if (bus.rsp_valid !== 1'b0 || count !== 4'(2 - i)) begin n_fail++; $display("FAIL pop%0d_n1 got v=%b cnt=%0d want 0 %0d", i, bus.rsp_valid, count, 2 - i); end
      tick;
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d[i] || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL pop%0d_data got v=%b d=%h e=%b want 1 %h 0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_err, exp_d[i]); end
      tick;
      n_chk++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pop%0d_done got v=%b rdy=%b want 0 1", i, bus.rsp_valid, bus.cmd_ready); end
    end
    n_chk++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL b2b_end got cnt=%0d e=%b want 0 1", count, empty); end
    quiet;
  endtask

  task automatic test_overflow;
    quiet; flush;
    push_words(8, 16'h0000);
    n_chk++; if (full !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL ovf_full got f=%b cnt=%0d want 1 8", full, count); end
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_data = 16'hBEEF; #1;
    n_chk++; if (mem_load !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_load got load=%b rdy=%b want 0 1", mem_load, bus.cmd_ready); end
    tick; bus.cmd_valid = 1'b0;
    n_chk++; if (overflow_err !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL ovf_flag got o=%b cnt=%0d want 1 8", overflow_err, count); end
    for (int i = 0; i < 8; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.rsp_ready = 1'b1;
      tick; bus.cmd_valid = 1'b0; tick;
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'(7 - i)) begin n_fail++; $display("FAIL ovf_pop%0d got v=%b d=%h want 1 %h", i, bus.rsp_valid, bus.rsp_data, 16'(7 - i)); end
      tick;
    end
    n_chk++; if (overflow_err !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got o=%b e=%b want 1 1", overflow_err, empty); end
    flush;
    n_chk++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", overflow_err); end
    quiet;
  endtask

  task automatic test_underflow;
    quiet; flush;
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.rsp_ready = 1'b1; #1;
    n_chk++; if (mem_load !== 1'b0) begin n_fail++; $display("FAIL unf_load got %b want 0", mem_load); end
    tick; bus.cmd_valid = 1'b0;
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0 || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL unf_rsp got v=%b d=%h e=%b want 1 0000 1", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
    n_chk++; if (underflow_err !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL unf_flag got u=%b cnt=%0d want 1 0", underflow_err, count); end
    tick;
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL unf_after got v=%b e=%b u=%b want 0 0 1", bus.rsp_valid, bus.rsp_err, underflow_err); end
    quiet;
  endtask

  task automatic test_backpressure;
    quiet; flush;
    push_words(1, 16'hA5A5);
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.rsp_ready = 1'b0;
    tick; bus.cmd_op = 1'b0; bus.cmd_data = 16'hFFFF; tick;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hA5A5 || bus.cmd_ready !== 1'b0 || mem_load !== 1'b0) begin n_fail++; $display("FAIL stall%0d got v=%b d=%h rdy=%b load=%b want 1 a5a5 0 0", i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, mem_load); end
      tick;
    end
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1; tick;
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL stall_done got v=%b rdy=%b cnt=%0d want 0 1 0", bus.rsp_valid, bus.cmd_ready, count); end
    quiet;
  endtask

  task automatic test_clr;
    quiet; flush;
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.rsp_ready = 1'b1; tick; bus.cmd_valid = 1'b0; tick;
    push_words(4, 16'h4000);
    bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; tick; bus.cmd_valid = 1'b0; tick;
    n_chk++; if (bus.rsp_valid !== 1'b1 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL clr_pre got v=%b u=%b want 1 1", bus.rsp_valid, underflow_err); end
    clr = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; #1;
    n_chk++; if (bus.cmd_ready !== 1'b0 || mem_load !== 1'b0) begin n_fail++; $display("FAIL clr_block got rdy=%b load=%b want 0 0", bus.cmd_ready, mem_load); end
    tick; clr = 1'b0; bus.cmd_valid = 1'b0;
    n_chk++; if (count !== 4'd0 || bus.rsp_valid !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL clr_state got cnt=%0d v=%b o=%b u=%b want 0 0 0 0", count, bus.rsp_valid, overflow_err, underflow_err); end
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.rsp_ready = 1'b1; tick; bus.cmd_valid = 1'b0;
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL clr_pop got v=%b e=%b want 1 1", bus.rsp_valid, bus.rsp_err); end
    tick; quiet; stk.delete();
  endtask

  task automatic test_reset_mid_read;
    quiet; flush;
    push_words(6, 16'h6000);
    bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.rsp_ready = 1'b1; tick; bus.cmd_valid = 1'b0;
    n_chk++; if (count !== 4'd5 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_read_pre got cnt=%0d v=%b want 5 0", count, bus.rsp_valid); end
    rst_n = 1'b0; tick; rst_n = 1'b1; #1;
    n_chk++; if (count !== 4'd0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_read got cnt=%0d v=%b rdy=%b want 0 0 1", count, bus.rsp_valid, bus.cmd_ready); end
    tick;
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_read_idle got v=%b want 0", bus.rsp_valid); end
    quiet; stk.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_random;
    logic [15:0] d, exp_d;
    bit          exp_e;
    int          lat, exp_lat, stall;
    quiet; flush;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        flush;
        n_chk++; if (count !== 4'd0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL rnd_clr it%0d got cnt=%0d o=%b u=%b want 0 0 0", it, count, overflow_err, underflow_err); end
      end else if ($urandom_range(0, 2) != 2) begin
        d = 16'($urandom);
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_data = d; #1;
        n_chk++; if (mem_load !== (stk.size() < 8)) begin n_fail++; $display("FAIL rnd_load it%0d got %b want %b", it, mem_load, stk.size() < 8); end
        tick; bus.cmd_valid = 1'b0;
        if (stk.size() < 8) stk.push_back(d); else m_ovf = 1;
        n_chk++; if (count !== 4'(stk.size()) || full !== (stk.size() == 8) || overflow_err !== m_ovf) begin n_fail++; $display("FAIL rnd_push it%0d got cnt=%0d f=%b o=%b want %0d %b %b", it, count, full, overflow_err, stk.size(), stk.size() == 8, m_ovf); end
      end else begin
        if (stk.size() == 0) begin exp_d = 16'h0; exp_e = 1; exp_lat = 1; m_unf = 1; end
        else begin exp_d = stk.pop_back(); exp_e = 0; exp_lat = 2; end
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.rsp_ready = 1'b0;
        tick; bus.cmd_valid = 1'b0; lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 5) begin tick; lat++; end
        n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_lat it%0d got %0d want %0d", it, lat, exp_lat); end
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) tick;
        n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_err !== exp_e) begin n_fail++; $display("FAIL rnd_pop it%0d got v=%b d=%h e=%b want 1 %h %b", it, bus.rsp_valid, bus.rsp_data, bus.rsp_err, exp_d, exp_e); end
        n_chk++; if (count !== 4'(stk.size()) || underflow_err !== m_unf || overflow_err !== m_ovf) begin n_fail++; $display("FAIL rnd_state it%0d got cnt=%0d u=%b o=%b want %0d %b %b", it, count, underflow_err, overflow_err, stk.size(), m_unf, m_ovf); end
        bus.rsp_ready = 1'b1; tick; bus.rsp_ready = 1'b0;
        n_chk++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_hs it%0d got v=%b rdy=%b want 0 1", it, bus.rsp_valid, bus.cmd_ready); end
      end
    end
    quiet;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet;
    test_reset;
    test_push_pop;
    test_overflow;
    test_underflow;
    test_backpressure;
    test_clr;
    test_reset_mid_read;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stack8_ctrl.md
STACK8_CTRL -- requirements
Module: stack8_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; no parameters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 clr  input  1  synchronous flush; empties stack, clears errors.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_op  input  1  0 = push, 1 = pop.
REQ-007 cmd_data  input  16  push payload.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-009 rsp_valid  output  1  pop result available.
REQ-010 rsp_data  output  16  popped word.
REQ-011 rsp_err  output  1  pop issued on empty stack; rsp_data = 0x0000.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-013 count  output  4  occupancy, 0..8.
REQ-014 full / empty  output  1 each  count==8 / count==0.
REQ-015 overflow_err / underflow_err  output  1 each  sticky error flags.
REQ-016 mem_address  output  3  to 8-word register memory (write on clk edge when mem_load, read combinational).
REQ-017 mem_load  output  1  memory write enable.
REQ-018 mem_in  output  16  memory write data.
REQ-019 mem_out  input  16  memory read data for mem_address, combinational.

Function
REQ-020 FSM states SHALL be IDLE, READ, RESP.
REQ-021 cmd_ready SHALL equal (state==IDLE) && !clr.
REQ-022 mem_address SHALL equal count[2:0] in every state (write slot when idle, top-of-stack index after pop decrement).
REQ-023 mem_in SHALL equal cmd_data combinationally.
REQ-024 mem_load SHALL be 1 only when in IDLE, rst_n=1, clr=0, push accepted, and !full.
REQ-025 Push accepted, !full: word written at index count in the same cycle; count increments next edge; state stays IDLE; one push per cycle sustained.
REQ-026 Push accepted, full: data dropped, no write, count unchanged, overflow_err set.
REQ-027 Pop accepted, !empty: count decrements next edge; state -> READ.
REQ-028 READ: rsp_data <= mem_out (address = new count); state -> RESP.
REQ-029 Pop accepted, empty: rsp_data <= 0x0000, rsp_err <= 1, underflow_err set, count stays 0; state -> RESP directly.
REQ-030 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid && rsp_ready; then state -> IDLE; rsp_err cleared on handshake.
REQ-031 Latency: pop accepted in cycle N -> rsp_valid in cycle N+2 (non-empty), N+1 (empty); next command acceptable in cycle after response handshake.
REQ-032 count SHALL never exceed 8 nor wrap below 0.
REQ-033 clr=1 in any state: next edge count=0, state=IDLE, rsp_valid=0, rsp_err=0, both error flags=0; any pending response discarded; cmd_ready=0 and mem_load=0 that cycle.
REQ-034 Error flags SHALL stay set until clr or reset.

Reset
REQ-035 rst_n=0 at a rising edge SHALL force state=IDLE, count=0, rsp_data=0x0000, rsp_err=0, overflow_err=0, underflow_err=0; rst_n has priority over clr and commands.
REQ-036 While rst_n=0, mem_load SHALL be 0 and cmd_ready SHALL be 0; memory contents are not cleared.
REQ-037 Reset mid-READ or mid-RESP SHALL abandon the response; rsp_valid=0 after the edge.

Verification
REQ-038 Push 0x1111,0x2222,0x3333 back-to-back, then 3 pops with rsp_ready=1 -> rsp_data 0x3333,0x2222,0x1111, each 2 cycles after accept; count 3->0; empty=1.
REQ-039 Push 8 words (0x0000..0x0007), push 0xBEEF -> full=1, mem_load=0 on 9th push, overflow_err=1; pops return 0x0007 first, 0xBEEF never.
REQ-040 Pop on empty -> rsp_valid next cycle, rsp_data=0x0000, rsp_err=1, underflow_err=1, count=0.
REQ-041 Pop with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held, cmd_ready=0 throughout; handshake -> IDLE next cycle.
REQ-042 Push 4 words, assert clr during RESP -> count=0, rsp_valid=0, errors=0 next edge; subsequent pop gives rsp_err=1.
REQ-043 Drive rst_n=0 one cycle during READ with count=5 -> count=0, rsp_valid=0, cmd_ready=1 after rst_n returns to 1.
